// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-stage stall/flush controller for an in-order pipeline.
// Arbitrates exceptions, data-memory wait, multi-cycle EX ops, redirects and
// load-use hazards. A redirect that arrives while its stage is frozen is held
// and replayed later. It also keeps saturating stall/flush cycle counters.
module pipeline_ctrl #(
  parameter int NUM_STAGES    = 5,
  parameter int DECODE_STAGE  = 1,
  parameter int RESOLVE_STAGE = 2,
  parameter int MEM_STAGE     = 3,
  parameter int XLEN          = 32,
  parameter int MC_W          = 6,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_req,
  input  logic [XLEN-1:0]       redirect_target,
  input  logic                  load_use,
  input  logic                  mem_busy,
  input  logic                  mc_start,
  input  logic [MC_W-1:0]       mc_len,
  input  logic                  exc_req,
  input  logic [XLEN-1:0]       exc_vector,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [1:0]            pc_sel,
  output logic [XLEN-1:0]       pc_target,
  output logic                  redirect_pending,
  output logic                  mc_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_RED = 2'd1;
  localparam logic [1:0] PC_EXC = 2'd2;

  // Contiguous bit range lo..hi set within a stage vector.
  function automatic logic [NUM_STAGES-1:0] range_mask(input int lo, input int hi);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      m[k] = (k >= lo) && (k <= hi);
    end
    return m;
  endfunction

  localparam int EXC_HI = (MEM_STAGE + 1 < NUM_STAGES - 1) ? MEM_STAGE + 1 : NUM_STAGES - 1;

  localparam logic [NUM_STAGES-1:0] MEM_STALL_MASK = range_mask(0, MEM_STAGE);
  localparam logic [NUM_STAGES-1:0] MC_STALL_MASK  = range_mask(0, RESOLVE_STAGE);
  localparam logic [NUM_STAGES-1:0] LU_STALL_MASK  = range_mask(0, DECODE_STAGE);
  localparam logic [NUM_STAGES-1:0] RED_FLUSH_MASK = range_mask(1, RESOLVE_STAGE);
  localparam logic [NUM_STAGES-1:0] EXC_FLUSH_MASK = range_mask(1, EXC_HI);

  state_t                state, state_nxt;
  logic [MC_W-1:0]       mc_cnt, mc_cnt_nxt;
  logic                  pend, pend_nxt;
  logic [XLEN-1:0]       pend_tgt, pend_tgt_nxt;
  logic                  mc_stall;
  logic                  frozen;
  logic [NUM_STAGES-1:0] base_stall;

  // Per-cycle arbitration of stall/flush/PC select plus next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    stall        = '0;
    flush        = '0;
    pc_sel       = PC_SEQ;
    pc_target    = '0;
    state_nxt    = state;
    mc_cnt_nxt   = mc_cnt;
    pend_nxt     = pend;
    pend_tgt_nxt = pend_tgt;
    mc_stall     = 1'b0;
    frozen       = 1'b0;
    base_stall   = '0;

    if (exc_req) begin
      // Trap wins over everything: kill younger work, abandon MC op and
      // any held redirect.
      flush      = EXC_FLUSH_MASK;
      pc_sel     = PC_EXC;
      pc_target  = exc_vector;
      state_nxt  = RUN;
      mc_cnt_nxt = '0;
      pend_nxt   = 1'b0;
    end else begin
      mc_stall   = (state == MC_WAIT) || (mc_start && (mc_len != '0));
      base_stall = (mem_busy ? MEM_STALL_MASK : '0) | (mc_stall ? MC_STALL_MASK : '0);
      frozen     = base_stall[RESOLVE_STAGE];

      if (!frozen && (pend || redirect_req)) begin
        // A held redirect is older than a fresh one, so it goes first.
        pc_sel    = PC_RED;
        pc_target = pend ? pend_tgt : redirect_target;
        stall     = base_stall;
        flush     = RED_FLUSH_MASK;
        pend_nxt  = 1'b0;
      end else begin
        stall = base_stall | (load_use ? LU_STALL_MASK : '0);
        // Bubble into the first register that advances behind a held one.
        flush = (stall << 1) & ~stall;
        if (frozen && redirect_req && !pend) begin
          pend_nxt     = 1'b1;
          pend_tgt_nxt = redirect_target;
        end
      end

      unique case (state)
        RUN: begin
          if (mc_start && (mc_len > MC_W'(1))) begin
            state_nxt  = MC_WAIT;
            mc_cnt_nxt = mc_len - MC_W'(1);
          end
        end
        MC_WAIT: begin
          mc_cnt_nxt = mc_cnt - MC_W'(1);
          if (mc_cnt == MC_W'(1)) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, countdown and held-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= RUN;
      mc_cnt   <= '0;
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state    <= state_nxt;
      mc_cnt   <= mc_cnt_nxt;
      pend     <= pend_nxt;
      pend_tgt <= pend_tgt_nxt;
    end
  end

  // Saturating counters of stalled-PC cycles and redirected-PC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall[0] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if ((pc_sel != PC_SEQ) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign redirect_pending = pend;
  assign mc_busy          = (state == MC_WAIT);

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised stall/flush controller for the N-stage in-order pipeline, generalising the branch-only flush logic to per-stage stall and flush vectors. It arbitrates exceptions, data-memory wait, multi-cycle EX operations, branch/jump redirects and load-use hazards. A redirect that arrives while its stage is frozen is held pending and applied later, never dropped. It also tracks a multi-cycle countdown and saturating performance counters. It sits between hazard detection and the pipeline registers and PC mux.

## Interface
- NUM_STAGES, 5, number of stages (IF, ID, EX, MEM, WB); vector bit k = register feeding stage k, bit 0 = PC
- DECODE_STAGE, 1, stage where load-use is detected
- RESOLVE_STAGE, 2, stage where branches resolve and multi-cycle ops run
- MEM_STAGE, 3, data-memory stage; exceptions are reported here
- XLEN, 32, address width
- MC_W, 6, width of multi-cycle length
- CNT_W, 16, performance counter width
- Legal: 1 ≤ DECODE_STAGE < RESOLVE_STAGE ≤ MEM_STAGE < NUM_STAGES
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_req  in  1  taken branch/jump at RESOLVE_STAGE
- redirect_target  in  XLEN  redirect PC
- load_use  in  1  load-use hazard at DECODE_STAGE
- mem_busy  in  1  data memory not ready
- mc_start  in  1  multi-cycle op begins at RESOLVE_STAGE
- mc_len  in  MC_W  total stall cycles for that op
- exc_req  in  1  exception at MEM_STAGE
- exc_vector  in  XLEN  trap handler PC
- stall  out  NUM_STAGES  hold register k
- flush  out  NUM_STAGES  load bubble into register k (bit 0 always 0)
- pc_sel  out  2  0 sequential, 1 redirect, 2 exception
- pc_target  out  XLEN  PC for pc_sel≠0, else 0
- redirect_pending  out  1  registered pending-redirect flag
- mc_busy  out  1  registered, FSM in MC_WAIT
- stall_cnt  out  CNT_W  cycles with stall[0]=1, saturating
- flush_cnt  out  CNT_W  cycles with pc_sel≠0, saturating

## Operation
- FSM: RUN, MC_WAIT. Orthogonal state: pending flag plus XLEN target register. Down-counter mc_cnt (MC_W bits).
- Per-cycle priority:
  1. exc_req: flush bits 1..min(MEM_STAGE+1, NUM_STAGES-1); stall=0; pc_sel=2; pc_target=exc_vector. Next state is RUN, mc_cnt=0, pending cleared. All other inputs are ignored.
  2. Stall sources, OR-ed. mem_busy asserts stall[0..MEM_STAGE]. MC stall asserts stall[0..RESOLVE_STAGE] when in MC_WAIT, or when in RUN with mc_start=1 and mc_len≠0.
  3. Stall-induced bubble: flush[k] = stall[k-1] & !stall[k] for k ≥ 1.
  4. frozen = stall[RESOLVE_STAGE] from step 2.
  5. Not frozen and (pending or redirect_req): pc_sel=1, flush bits 1..RESOLVE_STAGE. pc_target = pending target if pending, else redirect_target. Clear pending. load_use is ignored this cycle.
  6. Otherwise, load_use asserts stall[0..DECODE_STAGE], with bubbles per rule 3.
- Frozen and redirect_req and !pending: latch redirect_target and set pending. redirect_req while already pending is ignored.
- mc_start in RUN with mc_len=L≥2: go to MC_WAIT with mc_cnt=L-1. In MC_WAIT, decrement each cycle; when the decrement reaches 0, return to RUN. This gives exactly L stall cycles including the start cycle. L=1 stalls the start cycle only and stays in RUN. L=0 causes no stall.
- mc_start in MC_WAIT is ignored. mem_busy does not pause mc_cnt.
- Counters increment by 1 and hold at all-ones.

## Timing
- stall, flush, pc_sel and pc_target are combinational from inputs and registered state, and valid in the same cycle.
- Redirect latency: 0 cycles when not frozen; otherwise applied in the first unfrozen, non-exception cycle.
- Reset (async, rst_n=0): state RUN, mc_cnt=0, pending=0, target register=0, redirect_pending=0, mc_busy=0, stall_cnt=0, flush_cnt=0.
  - With all inputs low during and after reset: stall=0, flush=0, pc_sel=0, pc_target=0.
  - Reset mid-MC_WAIT or mid-pending discards both immediately.
- Counters update at the edge following the counted cycle.

## Test plan
- Default params. redirect_req=1 with target 0x100, no stalls -> same cycle pc_sel=1, pc_target=0x100, flush=5'b00110, stall=0. flush_cnt becomes 1.
- load_use=1 alone -> stall=5'b00011, flush=5'b00100. load_use together with redirect_req -> redirect only, stall=0.
- mem_busy=1 for 3 cycles with redirect_req pulse in cycle 1, target 0x200:
  - cycles 1-3: stall=5'b01111, flush=5'b10000.
  - redirect_pending=1 from cycle 2.
  - cycle 4: pc_sel=1, pc_target=0x200, pending clears.
  - stall_cnt=3.
- mc_start with mc_len=4 -> stall=5'b00111 and flush=5'b01000 for exactly 4 cycles; mc_busy=1 for the last 3; then RUN. mc_len=0 -> no stall.
- In MC_WAIT with pending redirect, exc_req=1 with vector 0x80 -> pc_sel=2, pc_target=0x80, flush=5'b11110, stall=0. Next cycle: RUN, no pending, no redirect issued.
- Assert rst_n=0 mid-MC_WAIT after 70000 stall cycles -> all outputs 0 immediately. Before reset, stall_cnt saturates at 0xFFFF.
